// File: rtl/text_line_controller_if.sv
// Write port of the text line controller.
//   master : writer side (drives wr_valid/wr_idx/wr_char/wr_commit, sees wr_ready)
//   slave  : controller side
interface text_line_controller_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [4:0] wr_idx;
   logic [7:0] wr_char;
   logic       wr_commit;

   modport master (output wr_valid, output wr_idx, output wr_char, output wr_commit,
                   input  wr_ready);
   modport slave  (input  wr_valid, input  wr_idx, input  wr_char, input  wr_commit,
                   output wr_ready);
endinterface

// File: rtl/text_line_controller.sv
// text_line_controller
//   Renders one line of NUM_CHARS glyphs through a shared bitmap lookup.
//   Writers edit a front buffer. A commit copies front->shadow at the next
//   frame_start, so the rendered line never tears.
// Ports
//   clk, rst         clock, async active-high reset
//   wr_if            write/commit port (slave modport)
//   i_vga_row/col    current scan position
//   i_frame_start    one-cycle pulse at start of vertical blanking
//   o_lookup_char    code sent to the shared bitmap lookup
//   i_bitmap_in      glyph for o_lookup_char, one clk after it
//   o_active         pixel on (3 clk after the coordinates were sampled)
//   o_commit_pending swap requested but not yet done
//   o_swap_done      pulse: swap performed
//   o_wr_err         pulse: accepted write addressed a slot past the line
module text_line_controller #(
   parameter int NUM_CHARS  = 8,
   parameter int SCALE      = 1,
   parameter int ORIGIN_ROW = 0,
   parameter int ORIGIN_COL = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   text_line_controller_if.slave  wr_if,
   input  logic [9:0]             i_vga_row,
   input  logic [9:0]             i_vga_col,
   input  logic                   i_frame_start,
   output logic [7:0]             o_lookup_char,
   input  logic [35:0]            i_bitmap_in,
   output logic                   o_active,
   output logic                   o_commit_pending,
   output logic                   o_swap_done,
   output logic                   o_wr_err
);
   localparam int         CELL   = 6 * SCALE;
   localparam logic [10:0] ROW_LO = 11'(ORIGIN_ROW);
   localparam logic [10:0] ROW_HI = 11'(ORIGIN_ROW + CELL);
   localparam logic [10:0] COL_LO = 11'(ORIGIN_COL);
   localparam logic [10:0] COL_HI = 11'(ORIGIN_COL + NUM_CHARS * CELL);

   typedef enum logic {IDLE, PEND} state_t;

   state_t                       r_state, w_state_nxt;
   logic [NUM_CHARS-1:0][7:0]    r_front, r_shadow, w_front_nxt;
   logic                         w_wr_acc, w_cm_acc, w_swap, w_wr_bad;

   // ---------------- write / commit side ----------------
   assign wr_if.wr_ready   = (r_state == IDLE);
   assign o_commit_pending = (r_state == PEND);
   assign w_wr_acc = wr_if.wr_valid  & wr_if.wr_ready;
   assign w_cm_acc = wr_if.wr_commit & wr_if.wr_ready;
   assign w_wr_bad = w_wr_acc & ({1'b0, wr_if.wr_idx} >= 6'(NUM_CHARS));

   // Front with this cycle's write applied, so a write+commit+frame_start
   // in one cycle still lands in the shadow copy.
   always_comb begin
      w_front_nxt = r_front;
      for (int i = 0; i < NUM_CHARS; i++)
         if (w_wr_acc && wr_if.wr_idx == 5'(i)) w_front_nxt[i] = wr_if.wr_char;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      case (r_state)
         IDLE: if (w_cm_acc) begin
            if (i_frame_start) w_swap = 1'b1;
            else               w_state_nxt = PEND;
         end
         PEND: if (i_frame_start) begin
            w_swap      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_front     <= {NUM_CHARS{8'h20}};
         r_shadow    <= {NUM_CHARS{8'h20}};
         o_swap_done <= 1'b0;
         o_wr_err    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_front     <= w_front_nxt;
         if (w_swap) r_shadow <= w_front_nxt;
         o_swap_done <= w_swap;
         o_wr_err    <= w_wr_bad;
      end
   end

   // ---------------- render pipeline ----------------
   logic [10:0] w_row11, w_col11, w_row_rel, w_col_rel;
   logic        w_hit;
   logic [4:0]  w_idx;
   logic [2:0]  w_cr, w_cc;
   logic [7:0]  w_sel;
   logic [1:0]  r_vld_pipe;          // hit flag at S1, S2
   logic [2:0]  r_cr1, r_cc1, r_cr2, r_cc2;
   logic [5:0]  w_bit;

   assign w_row11 = {1'b0, i_vga_row};
   assign w_col11 = {1'b0, i_vga_col};
   // Range test first; the subtractions below only matter on a hit.
   assign w_hit = (w_row11 >= ROW_LO) && (w_row11 < ROW_HI) &&
                  (w_col11 >= COL_LO) && (w_col11 < COL_HI);
   assign w_row_rel = w_row11 - ROW_LO;
   assign w_col_rel = w_col11 - COL_LO;
   assign w_idx = 5'(w_col_rel / 11'(CELL));
   assign w_cc  = 3'((w_col_rel / 11'(SCALE)) % 11'd6);
   assign w_cr  = 3'(w_row_rel / 11'(SCALE));

   always_comb begin
      w_sel = 8'h20;
      for (int i = 0; i < NUM_CHARS; i++)
         if (w_hit && w_idx == 5'(i)) w_sel = r_shadow[i];
   end

   assign w_bit = 6'd35 - (6'd6 * {3'b0, r_cr2} + {3'b0, r_cc2});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_lookup_char <= 8'h20;
         r_vld_pipe    <= '0;
         r_cr1         <= '0;
         r_cc1         <= '0;
         r_cr2         <= '0;
         r_cc2         <= '0;
         o_active      <= 1'b0;
      end else begin
         o_lookup_char <= w_sel;
         r_vld_pipe    <= {r_vld_pipe[0], w_hit};
         r_cr1         <= w_cr;
         r_cc1         <= w_cc;
         r_cr2         <= r_cr1;
         r_cc2         <= r_cc1;
         o_active      <= r_vld_pipe[1] & i_bitmap_in[w_bit];
      end
   end
endmodule

// File: tb/tb_text_line_controller.sv
module tb_text_line_controller;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;

   task automatic chk(string tag, logic [35:0] act, logic [35:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   // ---------------- DUT A: 8 chars, scale 1, origin (0,0) ----------------
   text_line_controller_if ifa();
   logic [9:0]  row_a = 10'd1000, col_a = 10'd1000;
   logic        fs_a = 1'b0;
   logic [7:0]  lk_a;
   logic [35:0] bm_a;
   logic        act_a, pend_a, sd_a, err_a;

   text_line_controller #(.NUM_CHARS(8), .SCALE(1), .ORIGIN_ROW(0), .ORIGIN_COL(0)) dut_a (
      .clk(clk), .rst(rst), .wr_if(ifa), .i_vga_row(row_a), .i_vga_col(col_a),
      .i_frame_start(fs_a), .o_lookup_char(lk_a), .i_bitmap_in(bm_a), .o_active(act_a),
      .o_commit_pending(pend_a), .o_swap_done(sd_a), .o_wr_err(err_a));

   // ---------------- DUT B: scale 2, origin (100,200) ----------------
   text_line_controller_if ifb();
   logic [9:0]  row_b = 10'd1000, col_b = 10'd1000;
   logic [7:0]  lk_b;
   logic [35:0] bm_b;
   logic        act_b, pend_b, sd_b, err_b;

   text_line_controller #(.NUM_CHARS(8), .SCALE(2), .ORIGIN_ROW(100), .ORIGIN_COL(200)) dut_b (
      .clk(clk), .rst(rst), .wr_if(ifb), .i_vga_row(row_b), .i_vga_col(col_b),
      .i_frame_start(1'b0), .o_lookup_char(lk_b), .i_bitmap_in(bm_b), .o_active(act_b),
      .o_commit_pending(pend_b), .o_swap_done(sd_b), .o_wr_err(err_b));

   // Glyph ROMs: one clk latency after lookup_char.
   function automatic logic [35:0] glyph(logic [7:0] c);
      return (c == 8'h20) ? 36'd0 : {c, c, c, c, 4'hA};
   endfunction
   always @(posedge clk) bm_a <= glyph(lk_a);
   always @(posedge clk) bm_b <= 36'h8_0000_0000;

   // ---------------- reference model ----------------
   logic [7:0] m_front [8];
   logic [7:0] m_shadow[8];
   logic [7:0] m_blank [8];

   function automatic logic [8:0] model(int r, int c, int orow, int ocol, int sc,
                                        logic [7:0] sh[8], bit only35);
      int idx, cc, cr;
      logic [7:0]  ch;
      logic [35:0] g;
      if (!(r >= orow && r < orow + 6*sc && c >= ocol && c < ocol + 8*6*sc))
         return {8'h20, 1'b0};
      idx = (c - ocol) / (6*sc);
      cc  = ((c - ocol) / sc) % 6;
      cr  = (r - orow) / sc;
      ch  = sh[idx];
      g   = only35 ? 36'h8_0000_0000 : glyph(ch);
      return {ch, g[35 - (6*cr + cc)]};
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {int due; logic [7:0] val;} sb_t;
   sb_t qa_lk[$], qa_act[$], qb_lk[$], qb_act[$];

   always @(negedge clk) begin
      sb_t e;
      while (qa_lk.size()  > 0 && qa_lk[0].due  <= cyc) begin e = qa_lk.pop_front();  chk("a_lookup", 36'(lk_a),  36'(e.val)); end
      while (qa_act.size() > 0 && qa_act[0].due <= cyc) begin e = qa_act.pop_front(); chk("a_active", 36'(act_a), 36'(e.val)); end
      while (qb_lk.size()  > 0 && qb_lk[0].due  <= cyc) begin e = qb_lk.pop_front();  chk("b_lookup", 36'(lk_b),  36'(e.val)); end
      while (qb_act.size() > 0 && qb_act[0].due <= cyc) begin e = qb_act.pop_front(); chk("b_active", 36'(act_b), 36'(e.val)); end
   end

   task automatic pix_a(int r, int c);
      logic [8:0] m;
      @(posedge clk); #1;
      row_a = 10'(r); col_a = 10'(c);
      m = model(r, c, 0, 0, 1, m_shadow, 1'b0);
      qa_lk.push_back('{cyc + 1, m[8:1]});
      qa_act.push_back('{cyc + 3, {7'b0, m[0]}});
   endtask

   task automatic pix_b(int r, int c);
      logic [8:0] m;
      @(posedge clk); #1;
      row_b = 10'(r); col_b = 10'(c);
      m = model(r, c, 100, 200, 2, m_blank, 1'b1);
      qb_lk.push_back('{cyc + 1, m[8:1]});
      qb_act.push_back('{cyc + 3, {7'b0, m[0]}});
   endtask

   task automatic drain();
      int k = 0;
      while ((qa_lk.size() + qa_act.size() + qb_lk.size() + qb_act.size()) > 0 && k < 20) begin
         @(posedge clk); k++;
      end
      chk("drain_left", 36'(qa_lk.size() + qa_act.size() + qb_lk.size() + qb_act.size()), 36'd0);
      row_a = 10'd1000; col_a = 10'd1000; row_b = 10'd1000; col_b = 10'd1000;
   endtask

   task automatic scan_a(int r0, int r1, int c1);
      for (int r = r0; r <= r1; r++)
         for (int c = 0; c <= c1; c++) pix_a(r, c);
      drain();
   endtask

   // One-cycle request on port A; returns 1 time unit after the sampling edge.
   task automatic drv(bit v, logic [4:0] idx, logic [7:0] ch, bit cm, bit fs);
      @(posedge clk); #1;
      ifa.wr_valid = v; ifa.wr_idx = idx; ifa.wr_char = ch; ifa.wr_commit = cm; fs_a = fs;
      @(posedge clk); #1;
      ifa.wr_valid = 1'b0; ifa.wr_commit = 1'b0; fs_a = 1'b0;
   endtask

   task automatic do_swap_model();
      for (int i = 0; i < 8; i++) m_shadow[i] = m_front[i];
   endtask

   initial begin
      ifa.wr_valid = 0; ifa.wr_idx = 0; ifa.wr_char = 0; ifa.wr_commit = 0;
      ifb.wr_valid = 0; ifb.wr_idx = 0; ifb.wr_char = 0; ifb.wr_commit = 0;
      for (int i = 0; i < 8; i++) begin m_front[i] = 8'h20; m_shadow[i] = 8'h20; m_blank[i] = 8'h20; end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_lookup", 36'(lk_a), 36'h20);
      chk("rst_active", 36'(act_a), 36'd0);
      chk("rst_pend",   36'(pend_a), 36'd0);
      chk("rst_swapd",  36'(sd_a), 36'd0);
      chk("rst_wrerr",  36'(err_a), 36'd0);
      @(negedge clk) rst = 1'b0;
      #1 chk("rdy_after_rst", 36'(ifa.wr_ready), 36'd1);

      // 1: blank line
      scan_a(0, 0, 47);

      // 2: write + commit + frame_start
      drv(1, 5'd0, 8'h41, 0, 0); m_front[0] = 8'h41;
      chk("pend_after_wr", 36'(pend_a), 36'd0);
      drv(0, 5'd0, 8'h00, 1, 0);
      chk("pend_after_cm", 36'(pend_a), 36'd1);
      chk("rdy_in_pend",   36'(ifa.wr_ready), 36'd0);
      chk("swapd_early",   36'(sd_a), 36'd0);
      drv(0, 5'd0, 8'h00, 0, 1); do_swap_model();
      chk("swapd_pulse",   36'(sd_a), 36'd1);
      chk("pend_cleared",  36'(pend_a), 36'd0);
      @(posedge clk); #1;
      chk("swapd_one_cyc", 36'(sd_a), 36'd0);
      scan_a(0, 6, 49);

      // frame_start without commit: nothing happens
      drv(0, 5'd0, 8'h00, 0, 1);
      chk("fs_idle_swapd", 36'(sd_a), 36'd0);
      chk("fs_idle_pend",  36'(pend_a), 36'd0);

      // 3: pending swap freezes the front buffer
      drv(1, 5'd1, 8'h42, 0, 0); m_front[1] = 8'h42;
      drv(0, 5'd0, 8'h00, 1, 0);
      chk("pend3", 36'(pend_a), 36'd1);
      chk("rdy3",  36'(ifa.wr_ready), 36'd0);
      drv(1, 5'd2, 8'h43, 0, 0);                 // refused
      chk("pend3_hold", 36'(pend_a), 36'd1);
      scan_a(0, 0, 47);                          // shadow still old
      drv(0, 5'd0, 8'h00, 0, 1); do_swap_model();
      chk("swapd3", 36'(sd_a), 36'd1);
      scan_a(0, 2, 47);

      // 4: write + commit + frame_start in one cycle
      drv(1, 5'd3, 8'h44, 1, 1); m_front[3] = 8'h44; do_swap_model();
      chk("pend4",   36'(pend_a), 36'd0);
      chk("swapd4",  36'(sd_a), 36'd1);
      chk("rdy4",    36'(ifa.wr_ready), 36'd1);
      scan_a(0, 5, 47);

      // 5: out-of-range slot
      drv(1, 5'd9, 8'h5A, 0, 0);
      chk("wrerr_pulse", 36'(err_a), 36'd1);
      @(posedge clk); #1;
      chk("wrerr_clear", 36'(err_a), 36'd0);
      drv(0, 5'd0, 8'h00, 1, 1); do_swap_model();
      chk("swapd5", 36'(sd_a), 36'd1);
      scan_a(0, 0, 47);

      // 6: scaled / offset instance
      pix_b(100, 200); pix_b(101, 201); pix_b(100, 202); pix_b(100, 199);
      pix_b(99, 200);  pix_b(111, 295); pix_b(112, 200); pix_b(100, 296);
      drain();

      // reset mid-operation clears pending commit and buffers
      drv(1, 5'd4, 8'h45, 0, 0);
      drv(0, 5'd0, 8'h00, 1, 0);
      chk("pend_before_rst", 36'(pend_a), 36'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_pend",   36'(pend_a), 36'd0);
      chk("midrst_lookup", 36'(lk_a), 36'h20);
      chk("midrst_active", 36'(act_a), 36'd0);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 8; i++) begin m_front[i] = 8'h20; m_shadow[i] = 8'h20; end
      drv(0, 5'd0, 8'h00, 1, 1);
      chk("swapd_post_rst", 36'(sd_a), 36'd1);
      scan_a(0, 0, 47);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
